div_issue_ctrl: RTL and testbench

- EX-stage sequencer sitting directly upstream of the multi-cycle divider (`div`).
- Detects a DIV/DIVU in EX, drives the divider's start/annul/operand handshake and holds a pipeline stall while the divider runs.
- Captures the 64-bit divider result and presents a one-cycle HI/LO write toward the HI/LO register file.
- Handles flushes so the divider always returns to its free state and never hands a stale result to the next divide.

---
 rtl/div_issue_ctrl_pkg.sv | 21 ++
 rtl/div_issue_ctrl.sv | 131 +++++++++++++
 tb/tb_div_issue_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/div_issue_ctrl_pkg.sv
// Shared constants for the divider issue sequencer: state encoding and the
// start/stop, ready/not-ready and zero-word values the divider also uses.
package div_issue_ctrl_pkg;

    localparam int DIV_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY  = 2'b01,
        DONE  = 2'b10,
        FLUSH = 2'b11
    } state_e;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    localparam logic [DIV_DATA_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/div_issue_ctrl.sv
// EX-stage sequencer for the multi-cycle divider: launch, stall, annul on flush,
// one-cycle HI/LO write. Optional macro DIV_ZERO_FASTPATH_EN skips the divider for x/0.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                is_div_i,
    input  logic                signed_i,
    input  logic [DATA_W-1:0]   op1_i,
    input  logic [DATA_W-1:0]   op2_i,
    input  logic                flush_i,
    input  logic [2*DATA_W-1:0] div_result_i,
    input  logic                div_ready_i,
    output logic                div_start_o,
    output logic                div_annul_o,
    output logic                div_signed_o,
    output logic [DATA_W-1:0]   div_op1_o,
    output logic [DATA_W-1:0]   div_op2_o,
    output logic                stall_req_o,
    output logic                whilo_o,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   op1_q, op1_d, op2_q, op2_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic                signed_q, signed_d;
    logic                launch;
    logic                zero_div;

    assign launch = is_div_i && !flush_i;

`ifdef DIV_ZERO_FASTPATH_EN
    assign zero_div = (op2_i == ZERO_WORD);
`else
    assign zero_div = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        signed_d     = signed_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        div_start_o  = DIV_STOP;
        div_annul_o  = 1'b0;
        div_signed_o = 1'b0;
        div_op1_o    = '0;
        div_op2_o    = '0;
        stall_req_o  = 1'b0;
        whilo_o      = 1'b0;
        hi_o         = '0;
        lo_o         = '0;

        case (state_q)
            IDLE: begin
                if (launch) begin
                    stall_req_o = 1'b1;
                    op1_d       = op1_i;
                    op2_d       = op2_i;
                    signed_d    = signed_i;
                    if (zero_div) begin
                        // Result of x/0 is known: skip the divider entirely.
                        hi_d    = '0;
                        lo_d    = '0;
                        state_d = DONE;
                    end else begin
                        div_start_o  = DIV_START;
                        div_signed_o = signed_i;
                        div_op1_o    = op1_i;
                        div_op2_o    = op2_i;
                        state_d      = BUSY;
                    end
                end
            end
            BUSY: begin
                div_start_o  = DIV_START;
                stall_req_o  = 1'b1;
                div_signed_o = signed_q;
                div_op1_o    = op1_q;
                div_op2_o    = op2_q;
                // Flush beats a same-cycle ready so a killed divide never writes.
                if (flush_i) begin
                    div_annul_o = 1'b1;
                    state_d     = FLUSH;
                end else if (div_ready_i == DIV_RESULT_READY) begin
                    hi_d    = div_result_i[2*DATA_W-1:DATA_W];
                    lo_d    = div_result_i[DATA_W-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                whilo_o = !flush_i;
                if (!flush_i) begin
                    hi_o = hi_q;
                    lo_o = lo_q;
                end
                state_d = IDLE;
            end
            FLUSH: begin
                // One stop cycle lets the divider fall back to its free state.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op1_q    <= '0;
            op2_q    <= '0;
            signed_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            signed_q <= signed_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural fixed-latency divider.
module tb_div_issue_ctrl;

    localparam int LAT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        is_div_i = 1'b0;
    logic        signed_i = 1'b0;
    logic [31:0] op1_i = '0;
    logic [31:0] op2_i = '0;
    logic        flush_i = 1'b0;
    logic [63:0] div_result_i;
    logic        div_ready_i;
    logic        div_start_o, div_annul_o, div_signed_o;
    logic [31:0] div_op1_o, div_op2_o;
    logic        stall_req_o, whilo_o;
    logic [31:0] hi_o, lo_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    div_issue_ctrl dut (
        .clk(clk), .rst(rst), .is_div_i(is_div_i), .signed_i(signed_i),
        .op1_i(op1_i), .op2_i(op2_i), .flush_i(flush_i),
        .div_result_i(div_result_i), .div_ready_i(div_ready_i),
        .div_start_o(div_start_o), .div_annul_o(div_annul_o),
        .div_signed_o(div_signed_o), .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
        .stall_req_o(stall_req_o), .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    // Divider stand-in: free -> on (LAT cycles) -> end (holds ready until stop).
    logic [1:0]  m_st;
    logic [4:0]  m_cnt;
    logic [31:0] m_a, m_b;
    logic        m_s;
    logic [63:0] m_res;

    function automatic logic [63:0] div_model(input logic [31:0] a, b, input logic s);
        logic [31:0] q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            m_st <= 2'd0; m_cnt <= '0; m_a <= '0; m_b <= '0; m_s <= 1'b0; m_res <= '0;
        end else begin
            case (m_st)
                2'd0: if (div_start_o && !div_annul_o) begin
                    m_a <= div_op1_o; m_b <= div_op2_o; m_s <= div_signed_o;
                    m_cnt <= '0; m_st <= 2'd1;
                end
                2'd1: if (div_annul_o) m_st <= 2'd0;
                      else if (m_cnt == 5'(LAT-1)) begin
                          m_res <= div_model(m_a, m_b, m_s); m_st <= 2'd2;
                      end else m_cnt <= m_cnt + 5'd1;
                default: if (!div_start_o) m_st <= 2'd0;
            endcase
        end
    end

    assign div_ready_i  = (m_st == 2'd2);
    assign div_result_i = div_ready_i ? m_res : 64'd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Launch a divide, hold it in EX while stalled, check the DONE cycle, then
    // leave the bench sitting in the IDLE cycle right after DONE.
    task automatic run_div(input string tag, input logic [31:0] a, b, input logic s,
                           input logic [31:0] eh, el, input int est, input logic est_start);
        int   stalls = 0;
        int   n = 0;
        logic saw_start = 1'b0;
        is_div_i = 1'b1; signed_i = s; op1_i = a; op2_i = b;
        #1;
        chk({tag, "_launch_start"}, 64'(div_start_o), 64'(est_start));
        chk({tag, "_launch_ops"}, {div_op1_o, div_op2_o}, est_start ? {a, b} : 64'd0);
        while (!whilo_o && n < 64) begin
            if (stall_req_o) stalls++;
            if (div_start_o) saw_start = 1'b1;
            tick;
            n++;
        end
        chk({tag, "_done_seen"}, 64'(whilo_o), 64'd1);
        chk({tag, "_hi"}, 64'(hi_o), 64'(eh));
        chk({tag, "_lo"}, 64'(lo_o), 64'(el));
        chk({tag, "_stall_cycles"}, 64'(stalls), 64'(est));
        chk({tag, "_start_seen"}, 64'(saw_start), 64'(est_start));
        chk({tag, "_done_start_stall"}, {62'd0, div_start_o, stall_req_o}, 64'd0);
        is_div_i = 1'b0;
        tick;
    endtask

    initial begin
        logic saw_w;
        rst = 1'b1;
        tick; tick;
        chk("reset_strobes", {59'd0, div_start_o, div_annul_o, div_signed_o, stall_req_o, whilo_o}, 64'd0);
        chk("reset_hilo", {hi_o, lo_o}, 64'd0);
        chk("reset_ops", {div_op1_o, div_op2_o}, 64'd0);
        rst = 1'b0;
        tick;

        run_div("divu_100_7", 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, LAT + 2, 1'b1);
        run_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, LAT + 2, 1'b1);

        // Flush ten cycles into a divide.
        is_div_i = 1'b1; signed_i = 1'b0; op1_i = 32'd1000; op2_i = 32'd3;
        #1;
        chk("flush_launch_start", 64'(div_start_o), 64'd1);
        saw_w = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (whilo_o) saw_w = 1'b1;
        end
        chk("flush_busy_latched_op1", 64'(div_op1_o), 64'd1000);
        flush_i = 1'b1;
        #1;
        chk("flush_annul", 64'(div_annul_o), 64'd1);
        if (whilo_o) saw_w = 1'b1;
        tick;
        flush_i = 1'b0; is_div_i = 1'b0;
        #1;
        chk("flush_state_quiet", {60'd0, div_start_o, stall_req_o, div_annul_o, whilo_o}, 64'd0);
        if (whilo_o) saw_w = 1'b1;
        chk("flush_no_write", 64'(saw_w), 64'd0);
        tick;
        run_div("after_flush_9_3", 32'd9, 32'd3, 1'b0, 32'd0, 32'd3, LAT + 2, 1'b1);

`ifdef DIV_ZERO_FASTPATH_EN
        run_div("divu_by_zero", 32'd123, 32'd0, 1'b0, 32'd0, 32'd0, 1, 1'b0);
`else
        run_div("divu_by_zero", 32'd123, 32'd0, 1'b0, 32'd0, 32'd0, LAT + 2, 1'b1);
`endif

        run_div("b2b_20_6", 32'd20, 32'd6, 1'b0, 32'd2, 32'd3, LAT + 2, 1'b1);
        run_div("b2b_50_5", 32'd50, 32'd5, 1'b0, 32'd0, 32'd10, LAT + 2, 1'b1);

        // Reset mid-BUSY.
        is_div_i = 1'b1; signed_i = 1'b0; op1_i = 32'd1000; op2_i = 32'd7;
        for (int i = 0; i < 6; i++) tick;
        rst = 1'b1; is_div_i = 1'b0;
        tick;
        chk("rst_mid_strobes", {59'd0, div_start_o, div_annul_o, div_signed_o, stall_req_o, whilo_o}, 64'd0);
        chk("rst_mid_hilo_ops", {hi_o, lo_o} | {div_op1_o, div_op2_o}, 64'd0);
        rst = 1'b0;
        tick;
        run_div("after_rst_8_2", 32'd8, 32'd2, 1'b0, 32'd0, 32'd4, LAT + 2, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
